// File: rtl/fib_lpm_table.sv
// Forwarding table with longest-prefix-match lookup and runtime insert/update/delete.
// One operation at a time: a lookup walks every entry (SCAN) and a write walks every
// entry (WSEARCH) before a single-cycle commit, so lookups never see partial writes.
module fib_lpm_table #(
  parameter int unsigned PREFIX_W = 64,
  parameter int unsigned LEN_W    = 7,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned IDX_W    = 4,
  parameter int unsigned PORT_W   = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                lookup_valid,
  output logic                lookup_ready,
  input  logic [PREFIX_W-1:0] lookup_prefix,
  input  logic [LEN_W-1:0]    lookup_len,
  output logic                result_valid,
  input  logic                result_ready,
  output logic                result_hit,
  output logic [PORT_W-1:0]   result_port,
  output logic [LEN_W-1:0]    result_len,
  output logic [PREFIX_W-1:0] result_prefix,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic                wr_delete,
  input  logic [PREFIX_W-1:0] wr_prefix,
  input  logic [LEN_W-1:0]    wr_len,
  input  logic [PORT_W-1:0]   wr_port,
  output logic                wr_done,
  output logic                wr_err,
  output logic [IDX_W:0]      entry_count
);

  typedef enum logic [2:0] {StIdle, StScan, StResp, StWsearch, StWcommit} state_e;

  localparam logic [LEN_W-1:0] MaxLen  = LEN_W'(PREFIX_W);
  // Scan counter runs 0..DEPTH; the extra step is the hand-off cycle to RESP/WCOMMIT.
  localparam logic [IDX_W:0]   ScanEnd = (IDX_W+1)'(DEPTH);

  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
    return (len > MaxLen) ? MaxLen : len;
  endfunction

  // Ones in the top len bits.
  function automatic logic [PREFIX_W-1:0] len_mask(input logic [LEN_W-1:0] len);
    logic [PREFIX_W-1:0] ones;
    ones = '1;
    if (len == '0) return '0;
    return ones << (PREFIX_W - int'(len));
  endfunction

  state_e state_q, state_d;

  // Table storage; only the valid bits need reset.
  logic [DEPTH-1:0]    entry_valid_q;
  logic [LEN_W-1:0]    entry_len_q    [DEPTH];
  logic [PREFIX_W-1:0] entry_prefix_q [DEPTH];
  logic [PORT_W-1:0]   entry_port_q   [DEPTH];
  logic [IDX_W:0]      entry_count_q;

  // Registered request.
  logic                req_delete_q;
  logic [PREFIX_W-1:0] req_prefix_q;
  logic [LEN_W-1:0]    req_len_q;
  logic [PORT_W-1:0]   req_port_q;

  logic [IDX_W:0]      scan_q;
  logic                found_q, free_found_q;
  logic [IDX_W-1:0]    found_idx_q, free_idx_q;

  logic                res_hit_q;
  logic [PORT_W-1:0]   res_port_q;
  logic [LEN_W-1:0]    res_len_q;
  logic [PREFIX_W-1:0] res_prefix_q;
  logic                wr_done_q, wr_err_q;

  // Entry under examination and its match results.
  logic [IDX_W-1:0]    cur_idx;
  logic                cur_valid, scan_active, lpm_match, exact_match;
  logic [LEN_W-1:0]    cur_len;
  logic [PREFIX_W-1:0] cur_prefix;
  logic [LEN_W-1:0]    in_len;
  logic                do_update, do_alloc, do_delete, commit_err;

  always_comb begin
    cur_idx     = scan_q[IDX_W-1:0];
    scan_active = (scan_q != ScanEnd);
    cur_valid   = scan_active && entry_valid_q[cur_idx];
    cur_len     = entry_len_q[cur_idx];
    cur_prefix  = entry_prefix_q[cur_idx];
    lpm_match   = cur_valid && (cur_len <= req_len_q) &&
                  ((req_prefix_q & len_mask(cur_len)) == cur_prefix);
    exact_match = cur_valid && (cur_len == req_len_q) && (cur_prefix == req_prefix_q);
    in_len      = clamp_len(wr_valid ? wr_len : lookup_len);
  end

  // Commit decode from the search results.
  always_comb begin
    do_update  = !req_delete_q && found_q;
    do_alloc   = !req_delete_q && !found_q && free_found_q;
    do_delete  = req_delete_q && found_q;
    commit_err = !found_q && (req_delete_q || !free_found_q);
  end

  // Next-state logic; writes win over lookups in IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (wr_valid)          state_d = StWsearch;
        else if (lookup_valid) state_d = StScan;
      end
      StScan:    if (!scan_active) state_d = StResp;
      StResp:    if (result_ready) state_d = StIdle;
      StWsearch: if (!scan_active) state_d = StWcommit;
      StWcommit: state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Control state, request capture, scan bookkeeping and valid bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= StIdle;
      entry_valid_q <= '0;
      entry_count_q <= '0;
      req_delete_q  <= 1'b0;
      req_prefix_q  <= '0;
      req_len_q     <= '0;
      req_port_q    <= '0;
      scan_q        <= '0;
      found_q       <= 1'b0;
      free_found_q  <= 1'b0;
      found_idx_q   <= '0;
      free_idx_q    <= '0;
      res_hit_q     <= 1'b0;
      res_port_q    <= '0;
      res_len_q     <= '0;
      res_prefix_q  <= '0;
      wr_done_q     <= 1'b0;
      wr_err_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_done_q <= 1'b0;
      wr_err_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (wr_valid || lookup_valid) begin
            req_len_q    <= in_len;
            req_prefix_q <= (wr_valid ? wr_prefix : lookup_prefix) & len_mask(in_len);
            req_delete_q <= wr_delete;
            req_port_q   <= wr_port;
            scan_q       <= '0;
            found_q      <= 1'b0;
            free_found_q <= 1'b0;
          end
          if (!wr_valid && lookup_valid) begin
            res_hit_q    <= 1'b0;
            res_port_q   <= '0;
            res_len_q    <= '0;
            res_prefix_q <= '0;
          end
        end
        StScan: begin
          if (scan_active) scan_q <= scan_q + (IDX_W+1)'(1);
          // Longer match replaces; the default route only wins when nothing else hit.
          if (lpm_match && (!res_hit_q || cur_len > res_len_q)) begin
            res_hit_q    <= 1'b1;
            res_port_q   <= entry_port_q[cur_idx];
            res_len_q    <= cur_len;
            res_prefix_q <= cur_prefix;
          end
        end
        StWsearch: begin
          if (scan_active) scan_q <= scan_q + (IDX_W+1)'(1);
          if (exact_match) begin
            found_q     <= 1'b1;
            found_idx_q <= cur_idx;
          end
          if (scan_active && !entry_valid_q[cur_idx] && !free_found_q) begin
            free_found_q <= 1'b1;
            free_idx_q   <= cur_idx;
          end
        end
        StWcommit: begin
          wr_done_q <= 1'b1;
          wr_err_q  <= commit_err;
          if (do_alloc) begin
            entry_valid_q[free_idx_q] <= 1'b1;
            entry_count_q             <= entry_count_q + (IDX_W+1)'(1);
          end
          if (do_delete) begin
            entry_valid_q[found_idx_q] <= 1'b0;
            entry_count_q              <= entry_count_q - (IDX_W+1)'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Entry payload; written only at commit.
  always_ff @(posedge clk) begin
    if (state_q == StWcommit) begin
      if (do_alloc) begin
        entry_len_q[free_idx_q]    <= req_len_q;
        entry_prefix_q[free_idx_q] <= req_prefix_q;
        entry_port_q[free_idx_q]   <= req_port_q;
      end
      if (do_update) entry_port_q[found_idx_q] <= req_port_q;
    end
  end

  // Outputs.
  always_comb begin
    lookup_ready  = (state_q == StIdle);
    wr_ready      = (state_q == StIdle);
    result_valid  = (state_q == StResp);
    result_hit    = res_hit_q;
    result_port   = res_port_q;
    result_len    = res_len_q;
    result_prefix = res_prefix_q;
    wr_done       = wr_done_q;
    wr_err        = wr_err_q;
    entry_count   = entry_count_q;
  end

endmodule

// File: tb/tb_fib_lpm_table.sv
// Directed bench for fib_lpm_table with DEPTH=4.
module tb_fib_lpm_table;

  localparam int PW = 64;
  localparam int LW = 7;
  localparam int D  = 4;
  localparam int IW = 2;
  localparam int TW = 3;

  logic          clk, rst;
  logic          lookup_valid, lookup_ready, result_valid, result_ready, result_hit;
  logic [PW-1:0] lookup_prefix, result_prefix, wr_prefix;
  logic [LW-1:0] lookup_len, result_len, wr_len;
  logic [TW-1:0] result_port, wr_port;
  logic          wr_valid, wr_ready, wr_delete, wr_done, wr_err;
  logic [IW:0]   entry_count;

  int n_checks = 0;
  int n_fail   = 0;

  fib_lpm_table #(.PREFIX_W(PW), .LEN_W(LW), .DEPTH(D), .IDX_W(IW), .PORT_W(TW)) dut (
    .clk(clk), .rst(rst),
    .lookup_valid(lookup_valid), .lookup_ready(lookup_ready),
    .lookup_prefix(lookup_prefix), .lookup_len(lookup_len),
    .result_valid(result_valid), .result_ready(result_ready), .result_hit(result_hit),
    .result_port(result_port), .result_len(result_len), .result_prefix(result_prefix),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_delete(wr_delete),
    .wr_prefix(wr_prefix), .wr_len(wr_len), .wr_port(wr_port),
    .wr_done(wr_done), .wr_err(wr_err), .entry_count(entry_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  typedef struct {
    bit          is_wr;
    bit          del;
    logic [63:0] prefix;
    logic [6:0]  len;
    logic [2:0]  port;
    bit          exp_flag;   // wr_err for writes, result_hit for lookups
    logic [2:0]  exp_port;
    logic [6:0]  exp_len;
    logic [63:0] exp_prefix;
    int          exp_count;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk_w(bit del, logic [63:0] p, logic [6:0] l, logic [2:0] pt,
                                bit err, int cnt);
    vec_t v;
    v = '{1'b1, del, p, l, pt, err, 3'd0, 7'd0, 64'd0, cnt};
    return v;
  endfunction

  function automatic vec_t mk_l(logic [63:0] p, logic [6:0] l, bit hit, logic [2:0] pt,
                                logic [6:0] el, logic [63:0] ep);
    vec_t v;
    v = '{1'b0, 1'b0, p, l, 3'd0, hit, pt, el, ep, 0};
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (!(lookup_ready && wr_ready) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check({name, " idle timeout"}, 64'(n), 64'd0);
  endtask

  task automatic do_write(input string name, input bit del, input logic [63:0] p,
                          input logic [6:0] l, input logic [2:0] pt,
                          output int lat, output bit err);
    wait_idle(name);
    wr_valid = 1'b1; wr_delete = del; wr_prefix = p; wr_len = l; wr_port = pt;
    @(posedge clk);
    #1 wr_valid = 1'b0;
    lat = 0;
    err = 1'b0;
    while (lat < 50) begin
      @(posedge clk);
      #1 lat++;
      if (wr_done) break;
    end
    err = wr_err;
  endtask

  task automatic do_lookup(input string name, input logic [63:0] p, input logic [6:0] l,
                           output int lat);
    wait_idle(name);
    lookup_valid = 1'b1; lookup_prefix = p; lookup_len = l;
    @(posedge clk);
    #1 lookup_valid = 1'b0;
    lat = 0;
    while (lat < 50) begin
      @(posedge clk);
      #1 lat++;
      if (result_valid) break;
    end
  endtask

  initial begin
    int   lat;
    bit   err;
    bit   saw_result;
    logic [2:0]  hold_port;
    logic [6:0]  hold_len;
    logic [63:0] hold_pfx;

    rst = 1'b0;
    lookup_valid = 0; lookup_prefix = '0; lookup_len = '0; result_ready = 1'b1;
    wr_valid = 0; wr_delete = 0; wr_prefix = '0; wr_len = '0; wr_port = '0;

    vq.push_back(mk_w(0, 64'h0000FFFF0000FFFF, 7'd48, 3'd2, 0, 1));
    vq.push_back(mk_l(64'h0000FFFF0000FFFF, 7'd64, 1, 3'd2, 7'd48, 64'h0000FFFF00000000));
    vq.push_back(mk_w(0, 64'h0000000000000000, 7'd0, 3'd7, 0, 2));
    vq.push_back(mk_w(0, 64'h0000FFFF00000000, 7'd32, 3'd1, 0, 3));
    vq.push_back(mk_l(64'h0000FFFF12345678, 7'd64, 1, 3'd1, 7'd32, 64'h0000FFFF00000000));
    vq.push_back(mk_l(64'h1234000000000000, 7'd64, 1, 3'd7, 7'd0, 64'h0));
    vq.push_back(mk_l(64'h0000FFFF0000FFFF, 7'd40, 1, 3'd1, 7'd32, 64'h0000FFFF00000000));
    vq.push_back(mk_w(0, 64'hAB00000000000000, 7'd8, 3'd3, 0, 4));
    vq.push_back(mk_w(0, 64'hCD00000000000000, 7'd8, 3'd4, 1, 4));
    vq.push_back(mk_l(64'hCD00000000000000, 7'd64, 1, 3'd7, 7'd0, 64'h0));
    vq.push_back(mk_w(0, 64'hABFFFFFFFFFFFFFF, 7'd8, 3'd5, 0, 4));
    vq.push_back(mk_l(64'hAB12000000000000, 7'd16, 1, 3'd5, 7'd8, 64'hAB00000000000000));
    vq.push_back(mk_w(1, 64'h0000FFFF0000FFFF, 7'd48, 3'd0, 0, 3));
    vq.push_back(mk_l(64'h0000FFFF0000FFFF, 7'd64, 1, 3'd1, 7'd32, 64'h0000FFFF00000000));
    vq.push_back(mk_w(1, 64'h0000FFFF0000FFFF, 7'd48, 3'd0, 1, 3));
    vq.push_back(mk_l(64'h0000FFFF00000000, 7'd100, 1, 3'd1, 7'd32, 64'h0000FFFF00000000));
    vq.push_back(mk_w(0, 64'h0123456789ABCDEF, 7'd127, 3'd6, 0, 4));
    vq.push_back(mk_l(64'h0123456789ABCDEF, 7'd64, 1, 3'd6, 7'd64, 64'h0123456789ABCDEF));
    vq.push_back(mk_w(1, 64'h0123456789ABCDEF, 7'd64, 3'd0, 0, 3));

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst lookup_ready", 64'(lookup_ready), 64'd1);
    check("rst wr_ready", 64'(wr_ready), 64'd1);
    check("rst entry_count", 64'(entry_count), 64'd0);
    check("rst result_valid", 64'(result_valid), 64'd0);
    check("rst result_hit", 64'(result_hit), 64'd0);
    check("rst wr_done", 64'(wr_done), 64'd0);
    @(negedge clk) rst = 1'b1;

    foreach (vq[i]) begin
      if (vq[i].is_wr) begin
        do_write($sformatf("v%0d", i), vq[i].del, vq[i].prefix, vq[i].len, vq[i].port, lat, err);
        check($sformatf("v%0d wr latency", i), 64'(lat), 64'(D + 2));
        check($sformatf("v%0d wr_err", i), 64'(err), 64'(vq[i].exp_flag));
        check($sformatf("v%0d entry_count", i), 64'(entry_count), 64'(vq[i].exp_count));
      end else begin
        do_lookup($sformatf("v%0d", i), vq[i].prefix, vq[i].len, lat);
        check($sformatf("v%0d lookup latency", i), 64'(lat), 64'(D + 1));
        check($sformatf("v%0d result_hit", i), 64'(result_hit), 64'(vq[i].exp_flag));
        check($sformatf("v%0d result_port", i), 64'(result_port), 64'(vq[i].exp_port));
        check($sformatf("v%0d result_len", i), 64'(result_len), 64'(vq[i].exp_len));
        check($sformatf("v%0d result_prefix", i), result_prefix, vq[i].exp_prefix);
      end
    end

    // Simultaneous write and lookup: write first, lookup then sees the new route.
    wait_idle("sim");
    wr_valid = 1'b1; wr_delete = 1'b0; wr_prefix = 64'h5500000000000000; wr_len = 7'd8;
    wr_port = 3'd2;
    lookup_valid = 1'b1; lookup_prefix = 64'h55AA000000000000; lookup_len = 7'd64;
    result_ready = 1'b0;
    @(posedge clk);
    #1 wr_valid = 1'b0;
    check("sim lookup_ready during write", 64'(lookup_ready), 64'd0);
    lat = 0;
    while (lat < 50) begin
      @(posedge clk);
      #1 lat++;
      if (wr_done) break;
    end
    check("sim wr latency", 64'(lat), 64'(D + 2));
    check("sim wr_err", 64'(wr_err), 64'd0);
    check("sim entry_count", 64'(entry_count), 64'd4);
    @(posedge clk);
    #1 lookup_valid = 1'b0;
    lat = 0;
    while (lat < 50) begin
      @(posedge clk);
      #1 lat++;
      if (result_valid) break;
    end
    check("sim lookup latency", 64'(lat), 64'(D + 1));
    check("sim result_hit", 64'(result_hit), 64'd1);
    check("sim result_port", 64'(result_port), 64'd2);
    check("sim result_len", 64'(result_len), 64'd8);
    check("sim result_prefix", result_prefix, 64'h5500000000000000);
    hold_port = result_port; hold_len = result_len; hold_pfx = result_prefix;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("hold%0d result_valid", k), 64'(result_valid), 64'd1);
      check($sformatf("hold%0d lookup_ready", k), 64'(lookup_ready), 64'd0);
      check($sformatf("hold%0d port/len", k), {54'd0, result_port, result_len},
            {54'd0, hold_port, hold_len});
      check($sformatf("hold%0d prefix", k), result_prefix, hold_pfx);
    end
    result_ready = 1'b1;
    @(posedge clk);
    #1;
    check("release result_valid", 64'(result_valid), 64'd0);
    check("release lookup_ready", 64'(lookup_ready), 64'd1);

    // Asynchronous reset in the middle of a scan.
    wait_idle("rst");
    lookup_valid = 1'b1; lookup_prefix = 64'h55AA000000000000; lookup_len = 7'd64;
    @(posedge clk);
    #1 lookup_valid = 1'b0;
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("midrst lookup_ready", 64'(lookup_ready), 64'd1);
    check("midrst wr_ready", 64'(wr_ready), 64'd1);
    check("midrst entry_count", 64'(entry_count), 64'd0);
    @(negedge clk) rst = 1'b1;
    saw_result = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1 if (result_valid || wr_done) saw_result = 1'b1;
    end
    check("midrst no stale result", 64'(saw_result), 64'd0);
    do_lookup("postrst", 64'h55AA000000000000, 7'd64, lat);
    check("postrst lookup latency", 64'(lat), 64'(D + 1));
    check("postrst result_hit", 64'(result_hit), 64'd0);
    check("postrst result_port", 64'(result_port), 64'd0);
    check("postrst result_len", 64'(result_len), 64'd0);
    check("postrst result_prefix", result_prefix, 64'd0);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
